// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-outstanding instruction bus master feeding a
// two-entry (out register + skid) buffer toward IF/ID, with redirect kill.
module ifu_fetch #(
  parameter int                    PC_WIDTH   = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PC_WIDTH-1:0]   i_pc,
  input  logic                  i_flush,
  input  logic                  i_stall,
  output logic                  o_stall_req,
  output logic                  o_ibus_req,
  output logic [PC_WIDTH-1:0]   o_ibus_addr,
  input  logic                  i_ibus_gnt,
  input  logic                  i_ibus_rvalid,
  input  logic [INST_WIDTH-1:0] i_ibus_rdata,
  input  logic                  i_ibus_err,
  output logic                  o_inst_valid,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic [PC_WIDTH-1:0]   o_inst_pc,
  output logic                  o_inst_err
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic [PC_WIDTH-1:0]     pend_pc_r;

  logic                    out_valid_r;
  logic [INST_WIDTH-1:0]   out_inst_r;
  logic [PC_WIDTH-1:0]     out_pc_r;
  logic                    out_err_r;
  logic                    skid_valid_r;
  logic [INST_WIDTH-1:0]   skid_inst_r;
  logic [PC_WIDTH-1:0]     skid_pc_r;
  logic                    skid_err_r;

  logic                    pop_s;
  logic                    cap_s;
  logic                    issue_s;
  logic                    fire_s;
  logic [1:0]              cnt_next_s;
  logic [INST_WIDTH-1:0]   cap_inst_s;

  // Issue / capture decode and in-flight tracking next state
  always_comb begin
    state_next_s = state_r;
    pop_s        = out_valid_r & ~i_stall;
    cap_s        = (state_r == ST_BUSY) & i_ibus_rvalid & ~i_flush;
    cap_inst_s   = i_ibus_err ? NOP_INST : i_ibus_rdata;
    // Occupancy after this cycle; an issue is only allowed if the reply will fit.
    cnt_next_s   = {1'b0, out_valid_r} + {1'b0, skid_valid_r}
                 - {1'b0, pop_s} + {1'b0, cap_s};
    issue_s      = rst_n & ~i_flush
                 & ((state_r == ST_EMPTY) | ((state_r == ST_BUSY) & i_ibus_rvalid))
                 & (cnt_next_s <= 2'd1);
    fire_s       = issue_s & i_ibus_gnt;
    case (state_r)
      ST_EMPTY: begin
        if (fire_s) state_next_s = ST_BUSY;
        else        state_next_s = ST_EMPTY;
      end
      ST_BUSY: begin
        if (i_ibus_rvalid)  state_next_s = fire_s ? ST_BUSY : ST_EMPTY;
        else if (i_flush)   state_next_s = ST_DROP;
        else                state_next_s = ST_BUSY;
      end
      ST_DROP: begin
        if (i_ibus_rvalid) state_next_s = ST_EMPTY;
        else               state_next_s = ST_DROP;
      end
      default: state_next_s = ST_EMPTY;
    endcase
  end

  // In-flight state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= ST_EMPTY;
    else        state_r <= state_next_s;
  end

  // PC of the outstanding fetch, latched at grant
  always_ff @(posedge clk) begin
    if (!rst_n)      pend_pc_r <= {PC_WIDTH{1'b0}};
    else if (fire_s) pend_pc_r <= i_pc;
    else             pend_pc_r <= pend_pc_r;
  end

  // Out register + skid buffer; flush beats capture and pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_inst_r   <= NOP_INST;
      out_pc_r     <= {PC_WIDTH{1'b0}};
      out_err_r    <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_inst_r  <= NOP_INST;
      skid_pc_r    <= {PC_WIDTH{1'b0}};
      skid_err_r   <= 1'b0;
    end else if (i_flush) begin
      out_valid_r  <= 1'b0;
      out_inst_r   <= NOP_INST;
      out_err_r    <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (pop_s) begin
      if (skid_valid_r) begin
        out_valid_r <= 1'b1;
        out_inst_r  <= skid_inst_r;
        out_pc_r    <= skid_pc_r;
        out_err_r   <= skid_err_r;
        if (cap_s) begin
          skid_inst_r <= cap_inst_s;
          skid_pc_r   <= pend_pc_r;
          skid_err_r  <= i_ibus_err;
        end else begin
          skid_valid_r <= 1'b0;
        end
      end else if (cap_s) begin
        out_valid_r <= 1'b1;
        out_inst_r  <= cap_inst_s;
        out_pc_r    <= pend_pc_r;
        out_err_r   <= i_ibus_err;
      end else begin
        out_valid_r <= 1'b0;
        out_inst_r  <= NOP_INST;
        out_err_r   <= 1'b0;
      end
    end else if (cap_s) begin
      if (!out_valid_r) begin
        out_valid_r <= 1'b1;
        out_inst_r  <= cap_inst_s;
        out_pc_r    <= pend_pc_r;
        out_err_r   <= i_ibus_err;
      end else begin
        skid_valid_r <= 1'b1;
        skid_inst_r  <= cap_inst_s;
        skid_pc_r    <= pend_pc_r;
        skid_err_r   <= i_ibus_err;
      end
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign o_ibus_req   = issue_s;
  assign o_ibus_addr  = i_pc;
  assign o_stall_req  = ~rst_n | (~fire_s & ~i_flush);
  assign o_inst_valid = out_valid_r;
  assign o_inst       = out_inst_r;
  assign o_inst_pc    = out_pc_r;
  assign o_inst_err   = out_err_r;

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch against a queue-based model of the fetch buffer
// and outstanding request, with directed phases for stall, flush, no-grant and reset.
module tb_ifu_fetch;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_pc;
  logic        i_flush, i_stall, i_ibus_gnt, i_ibus_rvalid, i_ibus_err;
  logic [31:0] i_ibus_rdata;
  logic        o_stall_req, o_ibus_req, o_inst_valid, o_inst_err;
  logic [31:0] o_ibus_addr, o_inst, o_inst_pc;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n), .i_pc(i_pc), .i_flush(i_flush), .i_stall(i_stall),
    .o_stall_req(o_stall_req), .o_ibus_req(o_ibus_req), .o_ibus_addr(o_ibus_addr),
    .i_ibus_gnt(i_ibus_gnt), .i_ibus_rvalid(i_ibus_rvalid), .i_ibus_rdata(i_ibus_rdata),
    .i_ibus_err(i_ibus_err), .o_inst_valid(o_inst_valid), .o_inst(o_inst),
    .o_inst_pc(o_inst_pc), .o_inst_err(o_inst_err)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } ent_t;

  // model: buffered instructions in order, plus the single outstanding fetch
  ent_t        mq[$];
  bit          m_out, m_drop;
  logic [31:0] m_pend;
  // bus responder
  bit          b_pend;
  int          b_dly;
  // stimulus knobs
  int          p_gnt, p_stall, p_flush, p_stray, dly_max;
  bit          gnt_off, after_rst;
  logic [31:0] pc_r;
  int          n_checks = 0, n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycle(input bit do_rst);
    bit rv, er, fl, st, gn, ereq, estall, pop, cap;
    logic [31:0] rd;
    int cnt;
    ent_t e;
    @(negedge clk);
    if (mq.size() > 0) begin
      check_eq("inst_valid", o_inst_valid, 1'b1);
      check_eq("inst", o_inst, mq[0].inst);
      check_eq("inst_pc", o_inst_pc, mq[0].pc);
      check_eq("inst_err", o_inst_err, mq[0].err);
    end else begin
      check_eq("inst_valid", o_inst_valid, 1'b0);
      check_eq("inst_nop", o_inst, NOP);
    end
    if (after_rst) begin
      check_eq("rst_inst_pc", o_inst_pc, 32'h0);
      check_eq("rst_inst_err", o_inst_err, 1'b0);
      after_rst = 1'b0;
    end
    rv = 1'b0;
    if (b_pend) begin
      if (b_dly <= 1) rv = 1'b1;
      else b_dly--;
    end else if ($urandom_range(0, 99) < p_stray) begin
      rv = 1'b1;
    end
    rd = $urandom;
    er = ($urandom_range(0, 7) == 0);
    fl = !do_rst && ($urandom_range(0, 99) < p_flush);
    st = ($urandom_range(0, 99) < p_stall);
    gn = !gnt_off && ($urandom_range(0, 99) < p_gnt);
    rst_n = !do_rst; i_pc = pc_r; i_flush = fl; i_stall = st; i_ibus_gnt = gn;
    i_ibus_rvalid = rv; i_ibus_rdata = rd; i_ibus_err = er;

    pop    = (mq.size() > 0) && !st;
    cap    = m_out && !m_drop && rv && !fl;
    cnt    = mq.size() - int'(pop) + int'(cap);
    ereq   = !do_rst && !fl && (!m_out || (!m_drop && rv)) && (cnt <= 1);
    estall = do_rst || (!(ereq && gn) && !fl);
    #1;
    check_eq("ibus_req", o_ibus_req, ereq);
    check_eq("stall_req", o_stall_req, estall);
    check_eq("ibus_addr", o_ibus_addr, pc_r);

    if (do_rst) begin
      mq.delete(); m_out = 1'b0; m_drop = 1'b0; after_rst = 1'b1;
    end else begin
      if (fl) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (cap) begin
          e.inst = er ? NOP : rd; e.pc = m_pend; e.err = er;
          mq.push_back(e);
        end
      end
      if (m_out && rv) begin m_out = 1'b0; m_drop = 1'b0; end
      else if (fl && m_out) m_drop = 1'b1;
      if (ereq && gn) begin m_out = 1'b1; m_drop = 1'b0; m_pend = pc_r; end
    end
    if (rv) b_pend = 1'b0;
    if (ereq && gn) begin b_pend = 1'b1; b_dly = $urandom_range(1, dly_max); end
    if (fl) pc_r = 32'h100 + (32'($urandom_range(0, 15)) << 4);
    else if (!estall) pc_r = pc_r + 32'd4;
  endtask

  task automatic run(input int n, input int g, input int s, input int f, input int d);
    p_gnt = g; p_stall = s; p_flush = f; dly_max = d;
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  initial begin
    rst_n = 1'b0; i_pc = 32'h0; i_flush = 1'b0; i_stall = 1'b0; i_ibus_gnt = 1'b0;
    i_ibus_rvalid = 1'b0; i_ibus_rdata = 32'h0; i_ibus_err = 1'b0;
    pc_r = 32'h0; m_out = 1'b0; m_drop = 1'b0; m_pend = 32'h0; b_pend = 1'b0; b_dly = 0;
    p_gnt = 100; p_stall = 0; p_flush = 0; p_stray = 0; dly_max = 1;
    gnt_off = 1'b0; after_rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_valid", o_inst_valid, 1'b0);
    check_eq("reset_inst", o_inst, NOP);
    check_eq("reset_pc", o_inst_pc, 32'h0);
    check_eq("reset_err", o_inst_err, 1'b0);
    check_eq("reset_req", o_ibus_req, 1'b0);
    check_eq("reset_stall", o_stall_req, 1'b1);

    run(20, 100, 0, 0, 1);          // streaming, one per cycle
    run(40, 100, 70, 0, 1);         // consumer stalls, skid use
    run(40, 100, 20, 15, 2);        // redirects with fetches in flight
    gnt_off = 1'b1;
    run(4, 100, 0, 0, 1);           // bus refuses grant
    gnt_off = 1'b0;
    run(8, 100, 100, 0, 1);         // fill out + skid, then reset
    cycle(1'b1);
    p_stray = 30;
    run(10, 0, 0, 0, 1);            // stray responses after reset
    for (int b = 0; b < 20; b++) begin
      p_stray = $urandom_range(0, 10);
      run(100, $urandom_range(30, 100), $urandom_range(0, 60),
          $urandom_range(0, 10), $urandom_range(1, 3));
      if (b == 10) cycle(1'b1);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
